// File: rtl/ddr3_ctrl_pkg.sv
// Shared constants and helpers for the DDR3 controller host front-end.
package ddr3_ctrl_pkg;

  localparam int CMD_W = 3;

  localparam logic [CMD_W-1:0] CMD_SCR = 3'b001;
  localparam logic [CMD_W-1:0] CMD_SCW = 3'b010;

  // Width of one packed command word {cmd, addr, sz, op, data}.
  function automatic int cmd_pack_w(input int addr_w, input int sz_w,
                                    input int op_w, input int data_w);
    return CMD_W + addr_w + sz_w + op_w + data_w;
  endfunction

endpackage

// File: rtl/ddr3_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. rdata always shows the head
// entry; pushes to a full FIFO and pops from an empty FIFO are ignored.
// The occupancy count is registered and empty/full derive from it only,
// so a push while full is dropped even if a pop happens in the same cycle.
module ddr3_sync_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH_P2 = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic [WIDTH-1:0]    wdata,
  input  logic                pop,
  output logic [WIDTH-1:0]    rdata,
  output logic                empty,
  output logic                full,
  output logic [DEPTH_P2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_P2;
  localparam logic [DEPTH_P2:0] CNT_ONE  = (DEPTH_P2+1)'(1);
  localparam logic [DEPTH_P2:0] CNT_FULL = (DEPTH_P2+1)'(DEPTH);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_P2-1:0] wptr;
  logic [DEPTH_P2-1:0] rptr;
  logic                do_push;
  logic                do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];

  // Storage array; no reset needed since occupancy guards every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ddr3_mport_frontend.sv
// Multi-port host front-end for the DDR3 controller. Each client port has
// its own command FIFO; a round-robin arbiter drains them into a single
// registered issue slot, and tagged read returns are steered into per-port
// return FIFOs.
//
// Downstream handshake: ds_valid/ds_* form a single-entry register. A
// command transfers on a clock edge where ds_valid=1 and ds_ready=1. While
// ds_valid=1 and ds_ready=0 every ds_* field is held. ds_valid never drops
// without a transfer; ddr_ready only prevents a new command from loading.
module ddr3_mport_frontend
  import ddr3_ctrl_pkg::*;
#(
  parameter int NPORTS   = 2,
  parameter int ADDR_W   = 26,
  parameter int DATA_W   = 16,
  parameter int SZ_W     = 2,
  parameter int OP_W     = 3,
  parameter int DEPTH_P2 = 3,
  parameter int PID_W    = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CMD_W*NPORTS-1:0]       cmd,
  input  logic [ADDR_W*NPORTS-1:0]      addr,
  input  logic [SZ_W*NPORTS-1:0]        sz,
  input  logic [OP_W*NPORTS-1:0]        op,
  input  logic [DATA_W*NPORTS-1:0]      din,
  output logic [NPORTS-1:0]             notfull,
  output logic [(DEPTH_P2+1)*NPORTS-1:0] fillcount,
  input  logic                          ddr_ready,
  output logic                          ds_valid,
  input  logic                          ds_ready,
  output logic [PID_W-1:0]              ds_pid,
  output logic [CMD_W-1:0]              ds_cmd,
  output logic [ADDR_W-1:0]             ds_addr,
  output logic [SZ_W-1:0]               ds_sz,
  output logic [OP_W-1:0]               ds_op,
  output logic [DATA_W-1:0]             ds_data,
  input  logic                          rt_valid,
  input  logic [PID_W-1:0]              rt_pid,
  input  logic [ADDR_W-1:0]             rt_addr,
  input  logic [DATA_W-1:0]             rt_data,
  output logic [NPORTS-1:0]             rt_full,
  input  logic [NPORTS-1:0]             read,
  output logic [NPORTS-1:0]             validout,
  output logic [ADDR_W*NPORTS-1:0]      raddr,
  output logic [DATA_W*NPORTS-1:0]      dout,
  output logic                          err_ovf
);

  localparam int CW    = cmd_pack_w(ADDR_W, SZ_W, OP_W, DATA_W);
  localparam int RW    = ADDR_W + DATA_W;
  localparam int CNT_W = DEPTH_P2 + 1;
  localparam logic [CNT_W-1:0] RT_CNT_FULL = CNT_W'(1 << DEPTH_P2);

  logic [CW-1:0]     cmd_head [NPORTS];
  logic [NPORTS-1:0] cmd_empty;
  logic [NPORTS-1:0] cmd_full;
  logic [NPORTS-1:0] cmd_pop;

  logic [CNT_W-1:0]  rt_count [NPORTS];
  logic [NPORTS-1:0] rt_empty;
  logic [NPORTS-1:0] rt_fifo_full;
  logic [NPORTS-1:0] rt_sel;

  logic [PID_W-1:0]  rr_ptr;
  logic              win_found;
  int                win_idx;
  int                cand;
  logic [CW-1:0]     win_data;
  logic              load;
  logic              rt_drop;

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    logic [CMD_W-1:0]  pcmd;
    logic              pvalid;
    logic [DATA_W-1:0] pdata;

    assign pcmd   = cmd[p*CMD_W +: CMD_W];
    assign pvalid = (pcmd == CMD_SCR) || (pcmd == CMD_SCW);
    // Read commands carry no payload; store zeros so the slot is deterministic.
    assign pdata  = (pcmd == CMD_SCW) ? din[p*DATA_W +: DATA_W] : '0;

    ddr3_sync_fifo #(.WIDTH(CW), .DEPTH_P2(DEPTH_P2)) u_cmd_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (pvalid),
      .wdata ({pcmd, addr[p*ADDR_W +: ADDR_W], sz[p*SZ_W +: SZ_W],
               op[p*OP_W +: OP_W], pdata}),
      .pop   (cmd_pop[p]),
      .rdata (cmd_head[p]),
      .empty (cmd_empty[p]),
      .full  (cmd_full[p]),
      .count (fillcount[p*CNT_W +: CNT_W])
    );

    assign notfull[p] = ~cmd_full[p];
    assign rt_sel[p]  = rt_valid && (rt_pid == PID_W'(p));

    ddr3_sync_fifo #(.WIDTH(RW), .DEPTH_P2(DEPTH_P2)) u_rt_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (rt_sel[p]),
      .wdata ({rt_addr, rt_data}),
      .pop   (read[p]),
      .rdata ({raddr[p*ADDR_W +: ADDR_W], dout[p*DATA_W +: DATA_W]}),
      .empty (rt_empty[p]),
      .full  (rt_fifo_full[p]),
      .count (rt_count[p])
    );
  end

  // Round-robin search: first non-empty port at or after rr_ptr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 0;
    win_data  = '0;
    cand      = 0;
    for (int k = 0; k < NPORTS; k++) begin
      cand = (int'(rr_ptr) + k) % NPORTS;
      if (!win_found && !cmd_empty[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
        win_data  = cmd_head[cand];
      end
    end
  end

  assign load = (~ds_valid | ds_ready) & ddr_ready & win_found;

  // Pop the winning command FIFO in the same cycle the issue slot loads.
  always_comb begin
    cmd_pop = '0;
    for (int p = 0; p < NPORTS; p++) begin
      cmd_pop[p] = load && (win_idx == p);
    end
  end

  // Issue slot and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      ds_valid <= 1'b0;
      ds_pid   <= '0;
      ds_cmd   <= '0;
      ds_addr  <= '0;
      ds_sz    <= '0;
      ds_op    <= '0;
      ds_data  <= '0;
      rr_ptr   <= '0;
    end else if (load) begin
      ds_valid <= 1'b1;
      ds_pid   <= PID_W'(win_idx);
      {ds_cmd, ds_addr, ds_sz, ds_op, ds_data} <= win_data;
      rr_ptr   <= PID_W'((win_idx + 1) % NPORTS);
    end else if (ds_ready) begin
      ds_valid <= 1'b0;
    end
  end

  // A return beat is lost if its tag names no port or that port is full.
  assign rt_drop = rt_valid && ((int'(rt_pid) >= NPORTS) || |(rt_sel & rt_fifo_full));

  // Return-side status: registered availability, full flags, sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      validout <= '0;
      rt_full  <= '0;
      err_ovf  <= 1'b0;
    end else begin
      validout <= ~rt_empty;
      for (int p = 0; p < NPORTS; p++) begin
        rt_full[p] <= (rt_count[p] == RT_CNT_FULL);
      end
      if (rt_drop) err_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr3_mport_frontend.sv
// Directed bench for ddr3_mport_frontend with a command-stream scoreboard
// and a return-data scoreboard.
module tb_ddr3_mport_frontend;

  localparam int NP   = 2;
  localparam int AW   = 26;
  localparam int DW   = 16;
  localparam int SW   = 2;
  localparam int OW   = 3;
  localparam int DP2  = 3;
  localparam int PW   = 3;
  localparam int CNTW = DP2 + 1;
  localparam int EW   = PW + 3 + AW + SW + OW + DW;
  localparam logic [2:0] SCR = 3'b001;
  localparam logic [2:0] SCW = 3'b010;

  logic                clk = 1'b0;
  logic                reset;
  logic [3*NP-1:0]     cmd;
  logic [AW*NP-1:0]    addr;
  logic [SW*NP-1:0]    sz;
  logic [OW*NP-1:0]    op;
  logic [DW*NP-1:0]    din;
  logic [NP-1:0]       notfull;
  logic [CNTW*NP-1:0]  fillcount;
  logic                ddr_ready;
  logic                ds_valid;
  logic                ds_ready;
  logic [PW-1:0]       ds_pid;
  logic [2:0]          ds_cmd;
  logic [AW-1:0]       ds_addr;
  logic [SW-1:0]       ds_sz;
  logic [OW-1:0]       ds_op;
  logic [DW-1:0]       ds_data;
  logic                rt_valid;
  logic [PW-1:0]       rt_pid;
  logic [AW-1:0]       rt_addr;
  logic [DW-1:0]       rt_data;
  logic [NP-1:0]       rt_full;
  logic [NP-1:0]       read;
  logic [NP-1:0]       validout;
  logic [AW*NP-1:0]    raddr;
  logic [DW*NP-1:0]    dout;
  logic                err_ovf;

  int tests  = 0;
  int fails  = 0;
  int issued = 0;
  int base;

  logic [EW-1:0]    exp_q[$];
  logic [AW+DW-1:0] rt_q[$];

  ddr3_mport_frontend #(
    .NPORTS(NP), .ADDR_W(AW), .DATA_W(DW), .SZ_W(SW), .OP_W(OW),
    .DEPTH_P2(DP2), .PID_W(PW)
  ) dut (
    .clk(clk), .reset(reset), .cmd(cmd), .addr(addr), .sz(sz), .op(op),
    .din(din), .notfull(notfull), .fillcount(fillcount),
    .ddr_ready(ddr_ready), .ds_valid(ds_valid), .ds_ready(ds_ready),
    .ds_pid(ds_pid), .ds_cmd(ds_cmd), .ds_addr(ds_addr), .ds_sz(ds_sz),
    .ds_op(ds_op), .ds_data(ds_data), .rt_valid(rt_valid), .rt_pid(rt_pid),
    .rt_addr(rt_addr), .rt_data(rt_data), .rt_full(rt_full), .read(read),
    .validout(validout), .raddr(raddr), .dout(dout), .err_ovf(err_ovf)
  );

  // Clock and global watchdog.
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [EW-1:0] pack_exp(input int pid, input logic [2:0] c,
      input logic [AW-1:0] a, input logic [SW-1:0] s, input logic [OW-1:0] o,
      input logic [DW-1:0] d);
    return {PW'(pid), c, a, s, o, d};
  endfunction

  // Scoreboard: every accepted downstream command must match the queue head.
  always @(negedge clk) begin
    if (!reset && ds_valid && ds_ready) begin
      issued++;
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL ds_extra observed=%0h expected=no-command",
               {ds_pid, ds_cmd, ds_addr, ds_sz, ds_op, ds_data});
      end
      if (exp_q.size() != 0)
        check("ds_stream", 64'({ds_pid, ds_cmd, ds_addr, ds_sz, ds_op, ds_data}),
              64'(exp_q.pop_front()));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [2:0] c, input logic [AW-1:0] a,
      input logic [SW-1:0] s, input logic [OW-1:0] o, input logic [DW-1:0] d);
    cmd[p*3 +: 3]    = c;
    addr[p*AW +: AW] = a;
    sz[p*SW +: SW]   = s;
    op[p*OW +: OW]   = o;
    din[p*DW +: DW]  = d;
  endtask

  task automatic clear_inputs();
    cmd = '0; addr = '0; sz = '0; op = '0; din = '0;
    rt_valid = 1'b0; rt_pid = '0; rt_addr = '0; rt_data = '0; read = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    ddr_ready = 1'b0;
    ds_ready  = 1'b0;
    repeat (2) cyc();
    reset = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_notfull"}, 64'(notfull), 64'({NP{1'b1}}));
    check({tag, "_fillcount"}, 64'(fillcount), 64'(0));
    check({tag, "_ds_valid"}, 64'(ds_valid), 64'(0));
    check({tag, "_ds_fields"}, 64'({ds_pid, ds_cmd, ds_addr, ds_sz, ds_op, ds_data}), 64'(0));
    check({tag, "_validout"}, 64'(validout), 64'(0));
    check({tag, "_rt_full"}, 64'(rt_full), 64'(0));
    check({tag, "_err_ovf"}, 64'(err_ovf), 64'(0));
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      cyc();
    end
    check({tag, "_drain"}, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    ddr_ready = 1'b0;
    ds_ready  = 1'b0;

    // 1: reset values, single write through the issue slot.
    do_reset();
    check_reset("t1_rst");
    ddr_ready = 1'b1;
    ds_ready  = 1'b1;
    set_port(0, SCW, 26'h0000100, 2'd1, 3'd2, 16'hA5A5);
    exp_q.push_back(pack_exp(0, SCW, 26'h0000100, 2'd1, 3'd2, 16'hA5A5));
    cyc();
    clear_inputs();
    check("t1_fill_1", 64'(fillcount[0 +: CNTW]), 64'(1));
    check("t1_valid_early", 64'(ds_valid), 64'(0));
    cyc();
    check("t1_valid", 64'(ds_valid), 64'(1));
    check("t1_pid", 64'(ds_pid), 64'(0));
    check("t1_cmd", 64'(ds_cmd), 64'(SCW));
    check("t1_addr", 64'(ds_addr), 64'(26'h100));
    check("t1_data", 64'(ds_data), 64'(16'hA5A5));
    check("t1_fill_0", 64'(fillcount[0 +: CNTW]), 64'(0));
    cyc();
    check("t1_valid_done", 64'(ds_valid), 64'(0));

    // 2: both ports push three reads together; issue alternates 0,1,...
    do_reset();
    ddr_ready = 1'b1;
    ds_ready  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_port(0, SCR, AW'(32'h10 + i), SW'(i), 3'd0, DW'($urandom_range(0, 65535)));
      set_port(1, SCR, AW'(32'h20 + i), SW'(i), 3'd1, DW'($urandom_range(0, 65535)));
      exp_q.push_back(pack_exp(0, SCR, AW'(32'h10 + i), SW'(i), 3'd0, 16'h0));
      exp_q.push_back(pack_exp(1, SCR, AW'(32'h20 + i), SW'(i), 3'd1, 16'h0));
      cyc();
    end
    clear_inputs();
    wait_drain("t2");

    // 3: fill port 1 while issue is blocked; ninth push is dropped.
    do_reset();
    ds_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      set_port(1, SCR, AW'(32'h300 + i), 2'd0, 3'd3, 16'h0);
      if (i < 8) exp_q.push_back(pack_exp(1, SCR, AW'(32'h300 + i), 2'd0, 3'd3, 16'h0));
      cyc();
      check("t3_fill", 64'(fillcount[CNTW +: CNTW]), 64'((i < 8) ? i + 1 : 8));
      if (i == 7) check("t3_notfull", 64'(notfull), 64'(2'b01));
    end
    clear_inputs();
    check("t3_blocked", 64'(ds_valid), 64'(0));
    base = issued;
    ddr_ready = 1'b1;
    wait_drain("t3");
    repeat (3) cyc();
    check("t3_issued", 64'(issued - base), 64'(8));
    check("t3_idle", 64'(ds_valid), 64'(0));

    // 4: back-pressure holds the slot; release shows the next command.
    do_reset();
    ddr_ready = 1'b1;
    set_port(0, SCW, 26'h400, 2'd2, 3'd5, 16'hDEAD);
    exp_q.push_back(pack_exp(0, SCW, 26'h400, 2'd2, 3'd5, 16'hDEAD));
    cyc();
    set_port(0, SCW, 26'h401, 2'd3, 3'd6, 16'hBEEF);
    exp_q.push_back(pack_exp(0, SCW, 26'h401, 2'd3, 3'd6, 16'hBEEF));
    cyc();
    clear_inputs();
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("t4_hold_valid", 64'(ds_valid), 64'(1));
      check("t4_hold_fields", 64'({ds_pid, ds_cmd, ds_addr, ds_sz, ds_op, ds_data}),
            64'(pack_exp(0, SCW, 26'h400, 2'd2, 3'd5, 16'hDEAD)));
    end
    ds_ready = 1'b1;
    cyc();
    check("t4_next_valid", 64'(ds_valid), 64'(1));
    check("t4_next_addr", 64'(ds_addr), 64'(26'h401));
    check("t4_next_data", 64'(ds_data), 64'(16'hBEEF));
    cyc();
    check("t4_empty", 64'(ds_valid), 64'(0));
    check("t4_drain", 64'(exp_q.size()), 64'(0));

    // 5: single return beat to port 1, then pop it.
    do_reset();
    rt_valid = 1'b1; rt_pid = 3'd1; rt_addr = 26'h2000; rt_data = 16'h1234;
    cyc();
    clear_inputs();
    check("t5_lag", 64'(validout), 64'(0));
    cyc();
    check("t5_validout", 64'(validout), 64'(2'b10));
    check("t5_dout", 64'(dout[DW +: DW]), 64'(16'h1234));
    check("t5_raddr", 64'(raddr[AW +: AW]), 64'(26'h2000));
    read = 2'b10;
    cyc();
    read = 2'b00;
    cyc();
    check("t5_popped", 64'(validout), 64'(0));
    read = 2'b11;
    cyc();
    read = 2'b00;
    cyc();
    check("t5_empty_read", 64'(validout), 64'(0));

    // 6: overflow of return FIFO 0, sticky flag, then drain in order.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      rt_valid = 1'b1; rt_pid = 3'd0;
      rt_addr = AW'(32'h3000 + i); rt_data = DW'(32'h5000 + i);
      if (i < 8) rt_q.push_back({rt_addr, rt_data});
      cyc();
      if (i == 7) check("t6_no_ovf_yet", 64'(err_ovf), 64'(0));
    end
    clear_inputs();
    check("t6_ovf", 64'(err_ovf), 64'(1));
    check("t6_rt_full", 64'(rt_full), 64'(2'b01));
    repeat (3) cyc();
    check("t6_ovf_sticky", 64'(err_ovf), 64'(1));
    for (int i = 0; i < 8; i++) begin
      check("t6_head", 64'({raddr[0 +: AW], dout[0 +: DW]}), 64'(rt_q.pop_front()));
      read = 2'b01;
      cyc();
      read = 2'b00;
    end
    repeat (2) cyc();
    check("t6_drained", 64'(validout), 64'(0));
    check("t6_ovf_kept", 64'(err_ovf), 64'(1));

    // Tag beyond the port count is dropped and flagged.
    do_reset();
    rt_valid = 1'b1; rt_pid = 3'd2; rt_addr = 26'h1; rt_data = 16'h1;
    cyc();
    clear_inputs();
    cyc();
    check("t6_badpid_ovf", 64'(err_ovf), 64'(1));
    check("t6_badpid_valid", 64'(validout), 64'(0));

    // Reset in the middle of command and return traffic.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_port(0, SCW, AW'(32'h600 + i), 2'd1, 3'd1, DW'($urandom_range(0, 65535)));
      rt_valid = 1'b1; rt_pid = 3'd1;
      rt_addr = AW'(32'h700 + i); rt_data = DW'($urandom_range(0, 65535));
      cyc();
    end
    reset = 1'b1;
    cyc();
    check_reset("t6_mid");
    reset = 1'b0;
    clear_inputs();
    ddr_ready = 1'b1;
    ds_ready  = 1'b1;
    repeat (3) cyc();
    check("t6_post_ds", 64'(ds_valid), 64'(0));
    check("t6_post_validout", 64'(validout), 64'(0));
    check("t6_post_fill", 64'(fillcount), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
